cdp1802_dma_responder: RTL and testbench

CDP1802_DMA_RESPONDER -- requirements
Module: cdp1802_dma_responder

---
 rtl/cdp1802_dma_responder_pkg.sv | 18 +
 rtl/cdp1802_dma_responder_machine_cycle_timer.sv | 40 ++++
 rtl/cdp1802_dma_responder.sv | 129 ++++++++++++
 tb/tb_cdp1802_dma_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdp1802_dma_responder_pkg.sv
// Shared studio definitions: bus state codes, machine-cycle timing and responder states.
package cdp1802_dma_responder_pkg;

  localparam int TICKS_PER_CYCLE_DEFAULT = 8;
  localparam int DMA_CAPTURE_TICK        = 5;

  localparam logic [1:0] SC_FETCH     = 2'b00;
  localparam logic [1:0] SC_EXECUTE   = 2'b01;
  localparam logic [1:0] SC_DMA       = 2'b10;
  localparam logic [1:0] SC_INTERRUPT = 2'b11;

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_DMA  = 2'd1,
    ST_INTR = 2'd2
  } state_e;

endpackage

// File: rtl/cdp1802_dma_responder_machine_cycle_timer.sv
// Tick counter for one DMA/interrupt machine cycle; idles at zero while the CPU owns the bus.
module machine_cycle_timer
  import cdp1802_dma_responder_pkg::*;
#(
  parameter int TICKS = TICKS_PER_CYCLE_DEFAULT,
  parameter int CW    = (TICKS > 1) ? $clog2(TICKS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_i,
  input  logic          tick_en_i,
  output logic [CW-1:0] tick_o,
  output logic          last_o,
  output logic          capture_o
);

  logic [CW-1:0] tick_q, tick_d;

  assign last_o    = (tick_q == CW'(TICKS - 1));
  assign capture_o = (tick_q == CW'(DMA_CAPTURE_TICK));
  assign tick_o    = tick_q;

  always_comb begin
    tick_d = tick_q;
    if (!run_i) begin
      tick_d = '0;
    end else if (tick_en_i) begin
      tick_d = last_o ? '0 : tick_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/cdp1802_dma_responder.sv
// Steals bus machine cycles from the CPU core for video DMA-out and interrupt entry.
module cdp1802_dma_responder
  import cdp1802_dma_responder_pkg::*;
#(
  parameter int          TICKS_PER_CYCLE = TICKS_PER_CYCLE_DEFAULT,
  parameter logic [15:0] R0_RESET        = 16'h0900
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        dma_out_n,
  input  logic        int_req,
  input  logic        ie,
  input  logic        cpu_boundary,
  input  logic [1:0]  cpu_sc,
  input  logic        r0_load,
  input  logic [15:0] r0_in,
  input  logic [7:0]  mem_data,
  output logic [1:0]  sc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [7:0]  dma_data,
  output logic        dma_valid,
  output logic        cpu_hold,
  output logic        int_ack,
  output logic [15:0] r0,
  output state_e      dbg_state
);

  localparam int CW = (TICKS_PER_CYCLE > 1) ? $clog2(TICKS_PER_CYCLE) : 1;

  state_e        state_q, state_d;
  logic [15:0]   r0_q, r0_d;
  logic [7:0]    dma_data_q, dma_data_d;
  logic          dma_valid_q, dma_valid_d;
  logic          int_ack_q, int_ack_d;
  logic [CW-1:0] tick;
  logic          last_tick, capture_tick;

  machine_cycle_timer #(.TICKS(TICKS_PER_CYCLE), .CW(CW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run_i     (state_q != ST_CPU),
    .tick_en_i (clk_enable),
    .tick_o    (tick),
    .last_o    (last_tick),
    .capture_o (capture_tick)
  );

  // Requests are sampled only at cycle boundaries so a running cycle is never cut short.
  always_comb begin
    state_d     = state_q;
    r0_d        = r0_q;
    dma_data_d  = dma_data_q;
    dma_valid_d = 1'b0;
    int_ack_d   = 1'b0;
    if (clk_enable) begin
      case (state_q)
        ST_CPU: begin
          if (r0_load) r0_d = r0_in;
          if (cpu_boundary) begin
            if (!dma_out_n) begin
              state_d = ST_DMA;
            end else if (int_req && ie) begin
              state_d   = ST_INTR;
              int_ack_d = 1'b1;
            end
          end
        end
        ST_DMA: begin
          if (capture_tick) begin
            dma_data_d  = mem_data;
            dma_valid_d = 1'b1;
          end
          if (last_tick) begin
            r0_d = r0_q + 16'd1;
            if (!dma_out_n) begin
              state_d = ST_DMA;
            end else if (int_req && ie) begin
              state_d   = ST_INTR;
              int_ack_d = 1'b1;
            end else begin
              state_d = ST_CPU;
            end
          end
        end
        ST_INTR: begin
          if (last_tick) state_d = dma_out_n ? ST_CPU : ST_DMA;
        end
        default: state_d = ST_CPU;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CPU;
      r0_q        <= R0_RESET;
      dma_data_q  <= 8'h00;
      dma_valid_q <= 1'b0;
      int_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      dma_data_q  <= dma_data_d;
      dma_valid_q <= dma_valid_d;
      int_ack_q   <= int_ack_d;
    end
  end

  always_comb begin
    sc = cpu_sc;
    case (state_q)
      ST_DMA:  sc = SC_DMA;
      ST_INTR: sc = SC_INTERRUPT;
      default: sc = cpu_sc;
    endcase
  end

  assign mem_addr  = r0_q;
  assign mem_rd    = (state_q == ST_DMA) && (int'(tick) <= DMA_CAPTURE_TICK);
  assign cpu_hold  = (state_q != ST_CPU);
  assign dma_data  = dma_data_q;
  assign dma_valid = dma_valid_q;
  assign int_ack   = int_ack_q;
  assign r0        = r0_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// Directed bench for the DMA/interrupt responder with a byte scoreboard on dma_data.
module tb_cdp1802_dma_responder;
  import cdp1802_dma_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        dma_out_n = 1'b1;
  logic        int_req = 1'b0;
  logic        ie = 1'b0;
  logic        cpu_boundary = 1'b0;
  logic [1:0]  cpu_sc = 2'b00;
  logic        r0_load = 1'b0;
  logic [15:0] r0_in = 16'h0000;
  logic [7:0]  mem_data;
  logic [1:0]  sc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  dma_data;
  logic        dma_valid;
  logic        cpu_hold;
  logic        int_ack;
  logic [15:0] r0;
  state_e      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int rd_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  cdp1802_dma_responder dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .dma_out_n    (dma_out_n),
    .int_req      (int_req),
    .ie           (ie),
    .cpu_boundary (cpu_boundary),
    .cpu_sc       (cpu_sc),
    .r0_load      (r0_load),
    .r0_in        (r0_in),
    .mem_data     (mem_data),
    .sc           (sc),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .dma_data     (dma_data),
    .dma_valid    (dma_valid),
    .cpu_hold     (cpu_hold),
    .int_ack      (int_ack),
    .r0           (r0),
    .dbg_state    (dbg_state)
  );

  // Clock and memory
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign mem_data = mem_model(mem_addr);

  always @(negedge clk) begin
    if (dma_valid) got_q.push_back(dma_data);
    if (int_ack) ack_cnt++;
    if (mem_rd) rd_cnt++;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_vec++; if (dbg_state !== ST_CPU) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_CPU); end
    n_vec++; if (r0 !== 16'h0900) begin n_err++; $display("FAIL reset_r0 got=%h exp=0900", r0); end
    n_vec++; if (mem_addr !== 16'h0900) begin n_err++; $display("FAIL reset_addr got=%h exp=0900", mem_addr); end
    n_vec++; if (sc !== 2'b00) begin n_err++; $display("FAIL reset_sc got=%b exp=00", sc); end
    n_vec++; if ({mem_rd, dma_valid, cpu_hold, int_ack} !== 4'b0000) begin n_err++; $display("FAIL reset_strobes got=%b exp=0000", {mem_rd, dma_valid, cpu_hold, int_ack}); end
    n_vec++; if (dma_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", dma_data); end
    reset = 1'b0;
    got_q.delete(); ack_cnt = 0; rd_cnt = 0;
  endtask

  task automatic test_dma_burst();
    r0_load = 1'b1; r0_in = 16'h0900;
    step();
    r0_load = 1'b0;
    n_vec++; if (r0 !== 16'h0900) begin n_err++; $display("FAIL burst_load got=%h exp=0900", r0); end
    for (int i = 0; i < 8; i++) exp_q.push_back(mem_model(16'h0900 + 16'(i)));
    got_q.delete(); rd_cnt = 0;
    dma_out_n = 1'b0; cpu_boundary = 1'b1;
    step();
    cpu_boundary = 1'b0;
    n_vec++; if (dbg_state !== ST_DMA) begin n_err++; $display("FAIL burst_enter got=%0d exp=%0d", dbg_state, ST_DMA); end
    n_vec++; if ({sc, cpu_hold, mem_rd} !== 4'b1011) begin n_err++; $display("FAIL burst_bus got=%b exp=1011", {sc, cpu_hold, mem_rd}); end
    for (int i = 0; i < 64; i++) begin
      if (i == 60) dma_out_n = 1'b1;
      step();
    end
    n_vec++; if (dbg_state !== ST_CPU) begin n_err++; $display("FAIL burst_exit got=%0d exp=%0d", dbg_state, ST_CPU); end
    n_vec++; if (r0 !== 16'h0908) begin n_err++; $display("FAIL burst_r0 got=%h exp=0908", r0); end
    n_vec++; if ({cpu_hold, mem_rd} !== 2'b00) begin n_err++; $display("FAIL burst_release got=%b exp=00", {cpu_hold, mem_rd}); end
    n_vec++; if (rd_cnt !== 48) begin n_err++; $display("FAIL burst_rd_clks got=%0d exp=48", rd_cnt); end
    n_vec++; if (got_q.size() !== 8) begin n_err++; $display("FAIL burst_count got=%0d exp=8", got_q.size()); end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_vec++; if (g !== e) begin n_err++; $display("FAIL burst_data got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_dma_then_intr();
    exp_q.push_back(mem_model(16'h0908));
    exp_q.push_back(mem_model(16'h0909));
    got_q.delete(); ack_cnt = 0;
    ie = 1'b1; int_req = 1'b1; dma_out_n = 1'b0; cpu_boundary = 1'b1;
    step();
    cpu_boundary = 1'b0;
    n_vec++; if (dbg_state !== ST_DMA) begin n_err++; $display("FAIL prio_dma_first got=%0d exp=%0d", dbg_state, ST_DMA); end
    for (int i = 0; i < 16; i++) begin
      if (i == 10) dma_out_n = 1'b1;
      step();
    end
    n_vec++; if (dbg_state !== ST_INTR) begin n_err++; $display("FAIL prio_intr got=%0d exp=%0d", dbg_state, ST_INTR); end
    n_vec++; if ({sc, cpu_hold, mem_rd, int_ack} !== 5'b11101) begin n_err++; $display("FAIL intr_bus got=%b exp=11101", {sc, cpu_hold, mem_rd, int_ack}); end
    n_vec++; if (r0 !== 16'h090A) begin n_err++; $display("FAIL prio_r0 got=%h exp=090a", r0); end
    int_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    n_vec++; if ({dbg_state, int_ack} !== {ST_INTR, 1'b0}) begin n_err++; $display("FAIL intr_hold got=%b exp=%b", {dbg_state, int_ack}, {ST_INTR, 1'b0}); end
    step();
    n_vec++; if (dbg_state !== ST_CPU) begin n_err++; $display("FAIL intr_exit got=%0d exp=%0d", dbg_state, ST_CPU); end
    n_vec++; if (ack_cnt !== 1) begin n_err++; $display("FAIL intr_ack_count got=%0d exp=1", ack_cnt); end
    n_vec++; if (got_q.size() !== 2) begin n_err++; $display("FAIL prio_count got=%0d exp=2", got_q.size()); end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_vec++; if (g !== e) begin n_err++; $display("FAIL prio_data got=%h exp=%h", g, e); end
    end
    ie = 1'b0;
  endtask

  task automatic test_int_masked();
    ack_cnt = 0;
    ie = 1'b0; int_req = 1'b1; cpu_sc = 2'b01; cpu_boundary = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++; if ({dbg_state, sc, cpu_hold} !== {ST_CPU, 2'b01, 1'b0}) begin n_err++; $display("FAIL masked_cpu got=%b exp=%b", {dbg_state, sc, cpu_hold}, {ST_CPU, 2'b01, 1'b0}); end
    end
    cpu_sc = 2'b00;
    step();
    n_vec++; if (sc !== 2'b00) begin n_err++; $display("FAIL masked_sc got=%b exp=00", sc); end
    n_vec++; if (ack_cnt !== 0) begin n_err++; $display("FAIL masked_ack got=%0d exp=0", ack_cnt); end
    int_req = 1'b0; cpu_boundary = 1'b0;
  endtask

  task automatic test_wrap();
    r0_load = 1'b1; r0_in = 16'hFFFF;
    step();
    r0_load = 1'b0;
    got_q.delete(); rd_cnt = 0;
    dma_out_n = 1'b0; cpu_boundary = 1'b1;
    step();
    dma_out_n = 1'b1; cpu_boundary = 1'b0;
    n_vec++; if (mem_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_addr got=%h exp=ffff", mem_addr); end
    for (int i = 0; i < 8; i++) step();
    n_vec++; if (r0 !== 16'h0000) begin n_err++; $display("FAIL wrap_r0 got=%h exp=0000", r0); end
    n_vec++; if (dbg_state !== ST_CPU) begin n_err++; $display("FAIL wrap_exit got=%0d exp=%0d", dbg_state, ST_CPU); end
    n_vec++; if (rd_cnt !== 6) begin n_err++; $display("FAIL wrap_rd_clks got=%0d exp=6", rd_cnt); end
    n_vec++; if (got_q.size() !== 1) begin n_err++; $display("FAIL wrap_count got=%0d exp=1", got_q.size()); end
    else begin n_vec++; if (got_q[0] !== 8'h5A) begin n_err++; $display("FAIL wrap_data got=%h exp=5a", got_q[0]); end end
  endtask

  task automatic test_reset_mid_dma();
    dma_out_n = 1'b0; cpu_boundary = 1'b1;
    step();
    cpu_boundary = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_vec++; if ({dbg_state, mem_rd} !== {ST_DMA, 1'b1}) begin n_err++; $display("FAIL rstmid_pre got=%b exp=%b", {dbg_state, mem_rd}, {ST_DMA, 1'b1}); end
    got_q.delete();
    reset = 1'b1;
    step();
    n_vec++; if (dbg_state !== ST_CPU) begin n_err++; $display("FAIL rstmid_state got=%0d exp=%0d", dbg_state, ST_CPU); end
    n_vec++; if (r0 !== 16'h0900) begin n_err++; $display("FAIL rstmid_r0 got=%h exp=0900", r0); end
    n_vec++; if ({mem_rd, dma_valid, cpu_hold} !== 3'b000) begin n_err++; $display("FAIL rstmid_out got=%b exp=000", {mem_rd, dma_valid, cpu_hold}); end
    reset = 1'b0; dma_out_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_vec++; if (got_q.size() !== 0) begin n_err++; $display("FAIL rstmid_valid got=%0d exp=0", got_q.size()); end
    n_vec++; if (r0 !== 16'h0900) begin n_err++; $display("FAIL rstmid_r0_after got=%h exp=0900", r0); end
  endtask

  task automatic test_load_ignored();
    dma_out_n = 1'b0; cpu_boundary = 1'b1;
    step();
    dma_out_n = 1'b1; cpu_boundary = 1'b0;
    r0_load = 1'b1; r0_in = 16'h1234;
    for (int i = 0; i < 8; i++) step();
    r0_load = 1'b0;
    n_vec++; if (r0 !== 16'h0901) begin n_err++; $display("FAIL load_ignored got=%h exp=0901", r0); end
    n_vec++; if (dbg_state !== ST_CPU) begin n_err++; $display("FAIL load_exit got=%0d exp=%0d", dbg_state, ST_CPU); end
  endtask

  task automatic test_clk_enable_hold();
    clk_enable = 1'b0; dma_out_n = 1'b0; cpu_boundary = 1'b1;
    step();
    n_vec++; if (dbg_state !== ST_CPU) begin n_err++; $display("FAIL ce_no_entry got=%0d exp=%0d", dbg_state, ST_CPU); end
    clk_enable = 1'b1;
    step();
    cpu_boundary = 1'b0; dma_out_n = 1'b1;
    step(); step();
    got_q.delete();
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++; if ({dbg_state, mem_rd, dma_valid, r0} !== {ST_DMA, 1'b1, 1'b0, 16'h0901}) begin n_err++; $display("FAIL ce_hold got=%h exp=%h", {dbg_state, mem_rd, dma_valid, r0}, {ST_DMA, 1'b1, 1'b0, 16'h0901}); end
    end
    clk_enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_vec++; if (dbg_state !== ST_DMA) begin n_err++; $display("FAIL ce_still_dma got=%0d exp=%0d", dbg_state, ST_DMA); end
    step();
    n_vec++; if ({dbg_state, r0} !== {ST_CPU, 16'h0902}) begin n_err++; $display("FAIL ce_exit got=%h exp=%h", {dbg_state, r0}, {ST_CPU, 16'h0902}); end
    n_vec++; if (got_q.size() !== 1) begin n_err++; $display("FAIL ce_count got=%0d exp=1", got_q.size()); end
    else begin n_vec++; if (got_q[0] !== mem_model(16'h0901)) begin n_err++; $display("FAIL ce_data got=%h exp=%h", got_q[0], mem_model(16'h0901)); end end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_dma_burst();
    test_dma_then_intr();
    test_int_masked();
    test_wrap();
    test_reset_mid_dma();
    test_load_ignored();
    test_clk_enable_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
